// File: rtl/imem_loader_if.sv
// Bundles the loader's control, byte-stream and instruction-memory write signals.
// The slave modport is the loader; the master modport is whoever drives the stream and observes the writes.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err
    );

    modport master (
        output start, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length-prefixed little-endian byte stream in, one word write per 4 bytes.
// Define IMEM_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);

`ifdef IMEM_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;
`endif

    localparam int unsigned MAX_WORDS = 1 << ADDR_W;

    state_t            state;
    state_t            next_state;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       len_word;
    logic [ADDR_W:0]   word_cnt;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_buf;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              accept;
    logic              last_word;
    logic              in_ready_c;
    logic              busy_c;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    assign len_word  = {bus.in_data, len_lo};
    assign accept    = bus.in_valid & in_ready_c;
    assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (bus.start) next_state = LEN0;
            end
            LEN0: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
                if (bus.in_valid) next_state = LEN1;
            end
            LEN1: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
                if (bus.in_valid) begin
                    if (32'(len_word) > MAX_WORDS) next_state = ERR;
                    else if (len_word == 16'd0)    next_state = DONE;
                    else                           next_state = DATA;
                end
            end
            DATA: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
                if (bus.in_valid && byte_cnt == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                busy_c = 1'b1;
`ifdef IMEM_CHECKSUM_EN
                next_state = last_word ? CHK : DATA;
`else
                next_state = last_word ? DONE : DATA;
`endif
            end
`ifdef IMEM_CHECKSUM_EN
            CHK: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
                if (bus.in_valid) next_state = (bus.in_data == checksum) ? DONE : ERR;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // The word is assembled in asm_buf so wr_data only changes when a write is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            asm_buf   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMEM_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            if (bus.start && !busy_c) begin
                word_cnt <= '0;
                byte_cnt <= '0;
`ifdef IMEM_CHECKSUM_EN
                checksum <= '0;
`endif
            end
            if (accept) begin
                case (state)
                    LEN0: len_lo <= bus.in_data;
                    LEN1: len    <= len_word;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_CHECKSUM_EN
                        checksum <= checksum ^ bus.in_data;
`endif
                        case (byte_cnt)
                            2'd0: asm_buf[7:0]   <= bus.in_data;
                            2'd1: asm_buf[15:8]  <= bus.in_data;
                            2'd2: asm_buf[23:16] <= bus.in_data;
                            default: begin
                                wr_data_q <= {bus.in_data, asm_buf};
                                wr_addr_q <= word_cnt[ADDR_W-1:0];
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            if (state == WRITE) word_cnt <= word_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.wr_en     = (state == WRITE);
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.done      = (state == DONE);
    assign bus.err       = (state == ERR);
    assign bus.cpu_rst_n = rst & ~busy_c;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are modelled as byte lists, expected writes queued and
// compared by an independent write monitor. Honours IMEM_CHECKSUM_EN when defined.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    wr_t        exp_q[$];
    logic [7:0] payload[$];
    int         errors = 0;
    int         checks = 0;
    bit         gaps_on = 1'b0;
    bit         start_noise = 1'b0;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic flag_failure(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout, expected response within bound", name);
    endtask

    // Write monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", bus.wr_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_output("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                check_output("wr_data", bus.wr_data, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        int g;
        if (gaps_on) begin
            g = $urandom_range(0, 3);
            repeat (g) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.start    = start_noise && (bus.busy === 1'b1) && ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            bus.start = 1'b0;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) flag_failure("byte_accept");
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Reference model: word w of the frame is payload bytes 4w..4w+3, least significant first.
    task automatic apply_stimulus(input int n, input bit corrupt);
        logic [15:0] n16;
        logic [7:0]  x;
        n16 = 16'(n);
        x   = 8'h00;
        if (n <= DEPTH) begin
            for (int w = 0; w < n; w++) begin
                exp_q.push_back('{addr: ADDR_W'(w),
                                  data: {payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]}});
            end
            foreach (payload[i]) x = x ^ payload[i];
        end
        pulse_start();
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
        if (n <= DEPTH && n > 0) begin
            foreach (payload[i]) send_byte(payload[i]);
`ifdef IMEM_CHECKSUM_EN
            send_byte(corrupt ? (x ^ 8'h01) : x);
`endif
        end
    endtask

    task automatic finish_frame(input string name, input bit expect_done);
        int t;
        t = 0;
        while (bus.busy === 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) flag_failure({name, "_idle"});
        check_output({name, "_done"}, 32'(bus.done), 32'(expect_done));
        check_output({name, "_err"}, 32'(bus.err), 32'(!expect_done));
        check_output({name, "_cpu_rst_n"}, 32'(bus.cpu_rst_n), 32'd1);
        check_output({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check_output({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check_output({name, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        check_output({name, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check_output({name, "_wr_data"}, bus.wr_data, 32'd0);
        check_output({name, "_busy"}, 32'(bus.busy), 32'd0);
        check_output({name, "_done"}, 32'(bus.done), 32'd0);
        check_output({name, "_err"}, 32'(bus.err), 32'd0);
        check_output({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check_output({name, "_cpu_rst_n"}, 32'(bus.cpu_rst_n), 32'd0);
    endtask

    // Reset is asserted mid-cycle, away from either clock edge.
    task automatic async_reset(input string name);
        #2 rst = 1'b0;
        #1 check_reset_values(name);
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output({name, "_release_cpu_rst_n"}, 32'(bus.cpu_rst_n), 32'd1);
        check_output({name, "_release_in_ready"}, 32'(bus.in_ready), 32'd0);
        @(negedge clk);
    endtask

    task automatic load_test2_payload();
        payload = '{8'h67, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89};
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int t;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1 check_reset_values("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check_output("por_release_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
        @(negedge clk);

        $display("[TB] two-word frame");
        load_test2_payload();
        apply_stimulus(2, 1'b0);
        finish_frame("two_word", 1'b1);
        check_output("two_word_last_addr", 32'(bus.wr_addr), 32'd1);
        check_output("two_word_last_data", bus.wr_data, 32'h89ABCDEF);

        $display("[TB] empty frame");
        payload.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        check_output("empty_done_next_cycle", 32'(bus.done), 32'd1);
        finish_frame("empty", 1'b1);

        $display("[TB] oversize frames");
        apply_stimulus(DEPTH + 1, 1'b0);
        finish_frame("oversize_1025", 1'b0);
        pulse_start();
        check_output("restart_clears_err", 32'(bus.err), 32'd0);
        check_output("restart_busy", 32'(bus.busy), 32'd1);
        check_output("restart_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        finish_frame("after_err", 1'b1);
        apply_stimulus(65535, 1'b0);
        finish_frame("oversize_max", 1'b0);

        $display("[TB] async reset mid-load");
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        async_reset("mid_load");

        $display("[TB] stalled stream with start noise");
        gaps_on     = 1'b1;
        start_noise = 1'b1;
        load_test2_payload();
        apply_stimulus(2, 1'b0);
        finish_frame("gapped", 1'b1);

        load_test2_payload();
        exp_q.push_back('{addr: ADDR_W'(0), data: 32'h01234567});
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(payload[i]);
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_output("abort_first_write_seen", 32'(exp_q.size()), 32'd0);
        async_reset("abort");
        load_test2_payload();
        apply_stimulus(2, 1'b0);
        finish_frame("reload", 1'b1);

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 8);
            gaps_on = ($urandom_range(0, 1) == 1);
            payload.delete();
            for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
            apply_stimulus(n, 1'b0);
            finish_frame("random", 1'b1);
        end

        $display("[TB] full-depth frame");
        gaps_on     = 1'b0;
        start_noise = 1'b0;
        payload.delete();
        for (int i = 0; i < 4 * DEPTH; i++) payload.push_back(8'($urandom));
        apply_stimulus(DEPTH, 1'b0);
        finish_frame("full_depth", 1'b1);
        check_output("full_depth_last_addr", 32'(bus.wr_addr), 32'(DEPTH - 1));

`ifdef IMEM_CHECKSUM_EN
        $display("[TB] checksum mismatch");
        load_test2_payload();
        apply_stimulus(2, 1'b1);
        finish_frame("bad_checksum", 1'b0);
`endif

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
